// File: rtl/mpu_bus_pkg.sv
// mpu_bus_pkg -- shared encodings for the 68000-style bus initiator.
//   Command types, response status codes, function-code constants,
//   autovector base, FSM state enumeration, and the address-error rule.
package mpu_bus_pkg;

  typedef enum logic [1:0] {
    CMD_READ  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_IACK  = 2'd2,
    CMD_BAD   = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BUSERR  = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ADDRERR = 2'd3
  } rsp_status_e;

  localparam logic [2:0] FC_SUPER_DATA = 3'b101;
  localparam logic [2:0] FC_IACK       = 3'b111;
  localparam logic [7:0] AVEC_BASE     = 8'd24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_RELEASE,
    S_RESP
  } state_e;

  // Word access to an odd byte address, or the unused command encoding.
  function automatic logic is_addr_err(input logic [1:0] typ, input logic word,
                                       input logic a0);
    return (typ == CMD_BAD) || (word && a0);
  endfunction

endpackage

// File: rtl/ack_synchronizer.sv
// ack_synchronizer -- 2-flop synchronizer for the three bus acknowledges.
//   MCLK_IN   clock
//   RESET_IN  synchronous active-high reset (both stages cleared)
//   ACK_IN    {BERR, AVEC, DTACK}, asynchronous
//   ACK_SYNC  synchronized copy, two cycles behind ACK_IN
module ack_synchronizer (
  input  logic       MCLK_IN,
  input  logic       RESET_IN,
  input  logic [2:0] ACK_IN,
  output logic [2:0] ACK_SYNC
);

  logic [2:0] meta_q;

  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      meta_q   <= '0;
      ACK_SYNC <= '0;
    end else begin
      meta_q   <= ACK_IN;
      ACK_SYNC <= meta_q;
    end
  end

endmodule

// File: rtl/mpu_bus_initiator.sv
// mpu_bus_initiator -- runs one 68000-style bus cycle per command.
//   Command side : CMD_VALID_IN/CMD_READY handshake, CMD_TYPE_IN, CMD_WORD_IN,
//                  CMD_ADDR_IN, CMD_WDATA_IN.
//   Response side: RSP_VALID single-cycle pulse with RSP_STATUS and RSP_RDATA.
//   Bus side     : ADDR_OUT, FC_OUT, AS_OUT, UDS_OUT, LDS_OUT, WR_OUT,
//                  DATA_OUT/DATA_OE, DATA_IN; DTACK_IN/AVEC_IN/BERR_IN async.
//   MCLK_IN sole clock, RESET_IN synchronous active-high.
module mpu_bus_initiator
  import mpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        MCLK_IN,
  input  logic        RESET_IN,
  input  logic        CMD_VALID_IN,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_TYPE_IN,
  input  logic        CMD_WORD_IN,
  input  logic [23:0] CMD_ADDR_IN,
  input  logic [15:0] CMD_WDATA_IN,
  output logic        RSP_VALID,
  output logic [1:0]  RSP_STATUS,
  output logic [15:0] RSP_RDATA,
  output logic [23:0] ADDR_OUT,
  output logic [2:0]  FC_OUT,
  output logic        AS_OUT,
  output logic        UDS_OUT,
  output logic        LDS_OUT,
  output logic        WR_OUT,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  input  logic [15:0] DATA_IN,
  input  logic        DTACK_IN,
  input  logic        AVEC_IN,
  input  logic        BERR_IN
);

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  cmd_type_e   type_q;
  logic        word_q, a0_q;
  logic [2:0]  lvl_q;
  logic [23:0] bus_addr_q;
  logic [2:0]  fc_q;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic [15:0] cnt_q, cnt_inc;
  logic [1:0]  status_q, status_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rsp_ld;
  logic [2:0]  ack_sync;
  logic        berr_s, avec_s, dtack_s;
  logic        accept, bad_cmd, iack_cmd, as_on, bus_wide;

  ack_synchronizer u_ack_sync (
    .MCLK_IN  (MCLK_IN),
    .RESET_IN (RESET_IN),
    .ACK_IN   ({BERR_IN, AVEC_IN, DTACK_IN}),
    .ACK_SYNC (ack_sync)
  );

  assign {berr_s, avec_s, dtack_s} = ack_sync;

  assign accept   = (state_q == S_IDLE) && CMD_VALID_IN;
  assign bad_cmd  = is_addr_err(CMD_TYPE_IN, CMD_WORD_IN, CMD_ADDR_IN[0]);
  assign iack_cmd = (CMD_TYPE_IN == CMD_IACK);
  assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // ---------------- next state / response capture ----------------
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    rsp_ld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (CMD_VALID_IN) begin
          if (bad_cmd) begin
            state_d  = S_RESP;
            rsp_ld   = 1'b1;
            status_d = ST_ADDRERR;
            rdata_d  = '0;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        if (berr_s) begin
          state_d  = S_RELEASE;
          rsp_ld   = 1'b1;
          status_d = ST_BUSERR;
          rdata_d  = '0;
        end else if (avec_s) begin
          state_d = S_RELEASE;
          rsp_ld  = 1'b1;
          // Autovector is only meaningful as an answer to an IACK cycle.
          if (type_q == CMD_IACK) begin
            status_d = ST_OK;
            rdata_d  = {8'h00, AVEC_BASE + {5'd0, lvl_q}};
          end else begin
            status_d = ST_BUSERR;
            rdata_d  = '0;
          end
        end else if (dtack_s) begin
          state_d  = S_RELEASE;
          rsp_ld   = 1'b1;
          status_d = ST_OK;
          case (type_q)
            CMD_READ: rdata_d = word_q ? DATA_IN :
                                a0_q   ? {8'h00, DATA_IN[7:0]} :
                                         {8'h00, DATA_IN[15:8]};
            CMD_IACK: rdata_d = {8'h00, DATA_IN[7:0]};
            default:  rdata_d = '0;
          endcase
        end else if (cnt_inc == TO_CNT) begin
          state_d  = S_RELEASE;
          rsp_ld   = 1'b1;
          status_d = ST_TIMEOUT;
          rdata_d  = '0;
        end
      end
      // Wait for the responder to drop its acks so the next cycle cannot
      // see a stale one; a stuck ack is abandoned after the timeout.
      S_RELEASE: begin
        if ((ack_sync == 3'b000) || (cnt_inc == TO_CNT)) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge MCLK_IN) begin
    if (RESET_IN) begin
      state_q    <= S_IDLE;
      type_q     <= CMD_READ;
      word_q     <= 1'b0;
      a0_q       <= 1'b0;
      lvl_q      <= '0;
      bus_addr_q <= '0;
      fc_q       <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        type_q <= cmd_type_e'(CMD_TYPE_IN);
        word_q <= CMD_WORD_IN;
        a0_q   <= CMD_ADDR_IN[0];
        lvl_q  <= CMD_ADDR_IN[3:1];
        // Bus-facing fields only move for commands that use the bus, so
        // ADDR_OUT never changes underneath an asserted AS_OUT.
        if (!bad_cmd) begin
          bus_addr_q <= iack_cmd ? {20'hFFFFF, CMD_ADDR_IN[3:1], 1'b1} : CMD_ADDR_IN;
          fc_q       <= iack_cmd ? FC_IACK : FC_SUPER_DATA;
          wr_q       <= (CMD_TYPE_IN == CMD_WRITE);
          wdata_q    <= CMD_WORD_IN    ? CMD_WDATA_IN :
                        CMD_ADDR_IN[0] ? {2{CMD_WDATA_IN[7:0]}} :
                                         {2{CMD_WDATA_IN[15:8]}};
        end
      end
      if (rsp_ld) begin
        status_q <= status_d;
        rdata_q  <= rdata_d;
      end
      if (state_d != state_q)
        cnt_q <= '0;
      else if ((state_q == S_WAIT) || (state_q == S_RELEASE))
        cnt_q <= cnt_inc;
    end
  end

  // ---------------- outputs ----------------
  assign as_on    = (state_q == S_STROBE) || (state_q == S_WAIT);
  assign bus_wide = word_q || (type_q == CMD_IACK);

  assign CMD_READY  = (state_q == S_IDLE);
  assign RSP_VALID  = (state_q == S_RESP);
  assign RSP_STATUS = RSP_VALID ? status_q : 2'd0;
  assign RSP_RDATA  = RSP_VALID ? rdata_q : 16'd0;
  assign ADDR_OUT   = bus_addr_q;
  assign FC_OUT     = fc_q;
  assign WR_OUT     = wr_q;
  assign AS_OUT     = as_on;
  assign UDS_OUT    = as_on && (bus_wide || !a0_q);
  assign LDS_OUT    = as_on && (bus_wide || a0_q);
  // Write data stays driven for the first RELEASE cycle (counter still 0)
  // so it outlives the strobes by one cycle.
  assign DATA_OE    = wr_q && (as_on || ((state_q == S_RELEASE) && (cnt_q == 16'd0)));
  assign DATA_OUT   = DATA_OE ? wdata_q : 16'd0;

endmodule

// File: tb/tb_mpu_bus_initiator.sv
module tb_mpu_bus_initiator;

  localparam int TO = 8;

  logic        MCLK_IN, RESET_IN, CMD_VALID_IN, CMD_READY, CMD_WORD_IN;
  logic [1:0]  CMD_TYPE_IN, RSP_STATUS;
  logic [23:0] CMD_ADDR_IN, ADDR_OUT;
  logic [15:0] CMD_WDATA_IN, RSP_RDATA, DATA_OUT, DATA_IN;
  logic        RSP_VALID, AS_OUT, UDS_OUT, LDS_OUT, WR_OUT, DATA_OE;
  logic [2:0]  FC_OUT;
  logic        DTACK_IN, AVEC_IN, BERR_IN;

  int checks = 0;
  int errors = 0;

  mpu_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .MCLK_IN(MCLK_IN), .RESET_IN(RESET_IN),
    .CMD_VALID_IN(CMD_VALID_IN), .CMD_READY(CMD_READY),
    .CMD_TYPE_IN(CMD_TYPE_IN), .CMD_WORD_IN(CMD_WORD_IN),
    .CMD_ADDR_IN(CMD_ADDR_IN), .CMD_WDATA_IN(CMD_WDATA_IN),
    .RSP_VALID(RSP_VALID), .RSP_STATUS(RSP_STATUS), .RSP_RDATA(RSP_RDATA),
    .ADDR_OUT(ADDR_OUT), .FC_OUT(FC_OUT), .AS_OUT(AS_OUT),
    .UDS_OUT(UDS_OUT), .LDS_OUT(LDS_OUT), .WR_OUT(WR_OUT),
    .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
    .DTACK_IN(DTACK_IN), .AVEC_IN(AVEC_IN), .BERR_IN(BERR_IN)
  );

  initial MCLK_IN = 1'b0;
  always #5 MCLK_IN = ~MCLK_IN;

  typedef struct packed {
    logic        done;
    logic [7:0]  lat;        // edges from accept edge to RSP_VALID sample
    logic [1:0]  status;
    logic [15:0] rdata;
    logic        as_seen;
    logic        as_at0;
    logic [23:0] addr_at0;
    logic        addr_moved;
    logic        uds, lds, wr;
    logic [2:0]  fc;
    logic [23:0] addr;
    logic        oe_as;
    logic [15:0] dout;
    logic [3:0]  oe_tail;    // cycles DATA_OE stayed up after AS_OUT fell
    logic        ready_after;
    logic        rsp_after;
  } obs_t;

  task automatic tick();
    @(posedge MCLK_IN); #1;
  endtask

  // Issues one command and plays a responder that pulses the requested
  // ack pattern {BERR,AVEC,DTACK} for two cycles once it sees AS_OUT.
  task automatic run_cmd(input logic [1:0] typ, input logic word, input logic [23:0] addr,
                         input logic [15:0] wd, input logic [2:0] mode,
                         input logic [15:0] din, output obs_t o);
    int   pulse;
    logic acked;
    o = '0; pulse = 0; acked = 1'b0;
    CMD_TYPE_IN = typ; CMD_WORD_IN = word; CMD_ADDR_IN = addr; CMD_WDATA_IN = wd;
    DATA_IN = din; CMD_VALID_IN = 1'b1;
    tick();
    CMD_VALID_IN = 1'b0;
    o.addr_at0 = ADDR_OUT; o.as_at0 = AS_OUT;
    for (int k = 0; k < 40 && !o.done; k++) begin
      if (k > 0) tick();
      if (AS_OUT) begin
        o.as_seen = 1'b1;
        o.uds = UDS_OUT; o.lds = LDS_OUT; o.wr = WR_OUT; o.fc = FC_OUT; o.addr = ADDR_OUT;
        if (ADDR_OUT !== o.addr_at0) o.addr_moved = 1'b1;
        o.oe_as = DATA_OE; o.dout = DATA_OUT;
      end else if (o.as_seen && DATA_OE) begin
        o.oe_tail = o.oe_tail + 4'd1;
      end
      if (RSP_VALID) begin
        o.done = 1'b1; o.lat = 8'(k); o.status = RSP_STATUS; o.rdata = RSP_RDATA;
      end
      if (AS_OUT && !acked) begin acked = 1'b1; pulse = 2; end
      {BERR_IN, AVEC_IN, DTACK_IN} = (pulse > 0) ? mode : 3'b000;
      if (pulse > 0) pulse--;
    end
    {BERR_IN, AVEC_IN, DTACK_IN} = 3'b000;
    tick();
    o.ready_after = CMD_READY; o.rsp_after = RSP_VALID;
  endtask

  // Reference: what a command should produce, from the bus rules.
  function automatic void model(input logic [1:0] typ, input logic word, input logic [23:0] addr,
                                input logic [15:0] wd, input logic [2:0] mode, input logic [15:0] din,
                                output logic [1:0] st, output logic [15:0] rd, output int lat,
                                output logic on_bus, output logic [29:0] bus, output logic [15:0] dout);
    logic iack, bad;
    logic [2:0] lvl;
    iack = (typ == 2'd2);
    bad  = (typ == 2'd3) || (word && addr[0]);
    lvl  = addr[3:1];
    on_bus = !bad;
    bus  = {word | iack | ~addr[0], word | iack | addr[0], iack ? 3'b111 : 3'b101,
            typ == 2'd1, iack ? {20'hFFFFF, lvl, 1'b1} : addr};
    dout = word ? wd : (addr[0] ? {2{wd[7:0]}} : {2{wd[15:8]}});
    rd = 16'd0;
    if (bad) begin st = 2'd3; lat = 0; end
    else if (mode == 3'b000) begin st = 2'd2; lat = TO + 3; end
    else begin
      lat = 6;
      if (mode[2]) st = 2'd1;
      else if (mode[1]) begin
        st = iack ? 2'd0 : 2'd1;
        if (iack) rd = 16'd24 + 16'(lvl);
      end else begin
        st = 2'd0;
        if (typ == 2'd0) rd = word ? din : (addr[0] ? {8'h0, din[7:0]} : {8'h0, din[15:8]});
        else if (iack) rd = {8'h0, din[7:0]};
      end
    end
  endfunction

  task automatic test_reset();
    RESET_IN = 1'b1; CMD_VALID_IN = 1'b0; CMD_TYPE_IN = 2'd0; CMD_WORD_IN = 1'b0;
    CMD_ADDR_IN = '0; CMD_WDATA_IN = '0; DATA_IN = '0;
    DTACK_IN = 1'b0; AVEC_IN = 1'b0; BERR_IN = 1'b0;
    tick(); tick();
    checks++;
    if ({AS_OUT, UDS_OUT, LDS_OUT, WR_OUT, DATA_OE, RSP_VALID} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000",
                         {AS_OUT, UDS_OUT, LDS_OUT, WR_OUT, DATA_OE, RSP_VALID});
    end
    checks++;
    if ({ADDR_OUT, FC_OUT, DATA_OUT, RSP_STATUS, RSP_RDATA} !== '0) begin
      errors++; $display("FAIL reset_data got addr %h fc %b dout %h st %0d rd %h want all 0",
                         ADDR_OUT, FC_OUT, DATA_OUT, RSP_STATUS, RSP_RDATA);
    end
    checks++;
    if (CMD_READY !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", CMD_READY); end
    RESET_IN = 1'b0;
    tick();
  endtask

  task automatic test_word_read();
    obs_t o;
    run_cmd(2'd0, 1'b1, 24'h000100, 16'h0, 3'b001, 16'hBEEF, o);
    checks++;
    if ({o.done, o.status, o.rdata} !== {1'b1, 2'd0, 16'hBEEF}) begin
      errors++; $display("FAIL word_read_rsp got done %b st %0d rd %h want 1 0 beef", o.done, o.status, o.rdata);
    end
    checks++;
    if (o.lat !== 8'd6) begin errors++; $display("FAIL word_read_latency got %0d want 6", o.lat); end
    checks++;
    if ({o.uds, o.lds, o.wr, o.addr} !== {3'b110, 24'h000100}) begin
      errors++; $display("FAIL word_read_bus got uds %b lds %b wr %b addr %h want 1 1 0 000100",
                         o.uds, o.lds, o.wr, o.addr);
    end
    checks++;
    if ({o.ready_after, o.rsp_after} !== 2'b10) begin
      errors++; $display("FAIL word_read_after got ready %b rsp %b want 1 0", o.ready_after, o.rsp_after);
    end
  endtask

  task automatic test_byte_write();
    obs_t o;
    run_cmd(2'd1, 1'b0, 24'h100005, 16'h005A, 3'b001, 16'h1234, o);
    checks++;
    if ({o.uds, o.lds, o.wr} !== 3'b011) begin
      errors++; $display("FAIL byte_write_strobes got uds %b lds %b wr %b want 0 1 1", o.uds, o.lds, o.wr);
    end
    checks++;
    if ({o.oe_as, o.dout} !== {1'b1, 16'h5A5A}) begin
      errors++; $display("FAIL byte_write_data got oe %b dout %h want 1 5a5a", o.oe_as, o.dout);
    end
    checks++;
    if (o.oe_tail !== 4'd1) begin errors++; $display("FAIL byte_write_oe_tail got %0d want 1", o.oe_tail); end
    checks++;
    if ({o.status, o.rdata} !== {2'd0, 16'h0}) begin
      errors++; $display("FAIL byte_write_rsp got st %0d rd %h want 0 0000", o.status, o.rdata);
    end
  endtask

  task automatic test_addrerr();
    obs_t o;
    run_cmd(2'd0, 1'b1, 24'h000003, 16'h0, 3'b001, 16'hAAAA, o);
    checks++;
    if ({o.done, o.status, o.lat} !== {1'b1, 2'd3, 8'd0}) begin
      errors++; $display("FAIL addrerr_rsp got done %b st %0d lat %0d want 1 3 0", o.done, o.status, o.lat);
    end
    checks++;
    if (o.as_seen !== 1'b0) begin errors++; $display("FAIL addrerr_no_as got as %b want 0", o.as_seen); end
  endtask

  task automatic test_iack_avec();
    obs_t o;
    run_cmd(2'd2, 1'b1, 24'h000006, 16'h0, 3'b010, 16'h00C3, o);
    checks++;
    if ({o.fc, o.addr} !== {3'b111, 24'hFFFFF7}) begin
      errors++; $display("FAIL iack_bus got fc %b addr %h want 111 fffff7", o.fc, o.addr);
    end
    checks++;
    if ({o.status, o.rdata} !== {2'd0, 16'd27}) begin
      errors++; $display("FAIL iack_avec_rsp got st %0d rd %0d want 0 27", o.status, o.rdata);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_cmd(2'd0, 1'b1, 24'h800000, 16'h0, 3'b000, 16'h5555, o);
    checks++;
    if ({o.done, o.status, o.rdata} !== {1'b1, 2'd2, 16'h0}) begin
      errors++; $display("FAIL timeout_rsp got done %b st %0d rd %h want 1 2 0000", o.done, o.status, o.rdata);
    end
    checks++;
    if (o.lat !== 8'(TO + 3)) begin errors++; $display("FAIL timeout_latency got %0d want %0d", o.lat, TO + 3); end
  endtask

  task automatic test_berr_dtack();
    obs_t o;
    run_cmd(2'd0, 1'b1, 24'h000200, 16'h0, 3'b101, 16'h1111, o);
    checks++;
    if ({o.status, o.rdata} !== {2'd1, 16'h0}) begin
      errors++; $display("FAIL berr_priority got st %0d rd %h want 1 0000", o.status, o.rdata);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   seen;
    CMD_TYPE_IN = 2'd0; CMD_WORD_IN = 1'b1; CMD_ADDR_IN = 24'h000400; CMD_VALID_IN = 1'b1;
    tick();                 // accepted, SETUP
    CMD_VALID_IN = 1'b0;
    tick(); tick(); tick(); // STROBE, WAIT, WAIT
    checks++;
    if (AS_OUT !== 1'b1) begin errors++; $display("FAIL reset_mid_pre got as %b want 1", AS_OUT); end
    RESET_IN = 1'b1;
    tick();
    checks++;
    if ({AS_OUT, UDS_OUT, LDS_OUT, DATA_OE, RSP_VALID, CMD_READY} !== 6'b000001) begin
      errors++; $display("FAIL reset_mid_state got %b want 000001",
                         {AS_OUT, UDS_OUT, LDS_OUT, DATA_OE, RSP_VALID, CMD_READY});
    end
    RESET_IN = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (RSP_VALID) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL reset_mid_no_rsp got %0d pulses want 0", seen); end
    run_cmd(2'd0, 1'b1, 24'h000402, 16'h0, 3'b001, 16'h7E57, o);
    checks++;
    if ({o.status, o.rdata, o.lat} !== {2'd0, 16'h7E57, 8'd6}) begin
      errors++; $display("FAIL reset_mid_recover got st %0d rd %h lat %0d want 0 7e57 6", o.status, o.rdata, o.lat);
    end
  endtask

  task automatic test_random();
    logic [2:0] modes [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
    obs_t o;
    logic [1:0]  typ, st;
    logic        word, on_bus;
    logic [23:0] addr;
    logic [15:0] wd, din, rd, dout;
    logic [2:0]  mode;
    logic [29:0] bus;
    int          lat;
    for (int n = 0; n < 40; n++) begin
      typ  = 2'($urandom_range(0, 3));
      word = 1'($urandom);
      addr = 24'($urandom);
      wd   = 16'($urandom);
      din  = 16'($urandom);
      mode = modes[$urandom_range(0, 6)];
      model(typ, word, addr, wd, mode, din, st, rd, lat, on_bus, bus, dout);
      run_cmd(typ, word, addr, wd, mode, din, o);
      checks++;
      if ({o.done, o.status, o.rdata, o.lat} !== {1'b1, st, rd, 8'(lat)}) begin
        errors++; $display("FAIL rand%0d_rsp got done %b st %0d rd %h lat %0d want 1 %0d %h %0d",
                           n, o.done, o.status, o.rdata, o.lat, st, rd, lat);
      end
      checks++;
      if ({o.ready_after, o.rsp_after} !== 2'b10) begin
        errors++; $display("FAIL rand%0d_after got ready %b rsp %b want 1 0", n, o.ready_after, o.rsp_after);
      end
      checks++;
      if (!on_bus) begin
        if (o.as_seen !== 1'b0) begin errors++; $display("FAIL rand%0d_no_as got as %b want 0", n, o.as_seen); end
      end else begin
        if ({o.as_seen, o.as_at0, o.addr_moved, o.uds, o.lds, o.fc, o.wr, o.addr} !== {3'b100, bus}) begin
          errors++; $display("FAIL rand%0d_bus got %b/%b/%b %b want 1/0/0 %b",
                             n, o.as_seen, o.as_at0, o.addr_moved,
                             {o.uds, o.lds, o.fc, o.wr, o.addr}, bus);
        end
        if (typ == 2'd1) begin
          checks++;
          if ({o.oe_as, o.dout, o.oe_tail} !== {1'b1, dout, 4'd1}) begin
            errors++; $display("FAIL rand%0d_wdata got oe %b dout %h tail %0d want 1 %h 1",
                               n, o.oe_as, o.dout, o.oe_tail, dout);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_addrerr();
    test_iack_avec();
    test_timeout();
    test_berr_dtack();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
